// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    StOff,
    StReset,
    StWaitLock,
    StStable,
    StLocked,
    StFault
  } state_e;

  // Width needed to hold every value up to and including max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/pll_sup_channel.sv
// One supervised PLL: lock synchroniser, sequencing FSM, retry and lock-loss counters.
module pll_sup_channel
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned LOSS_CNT_W          = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  enable_i,
  input  logic                  clear_fault_i,
  input  logic                  lock_i,
  output logic                  pll_resetb_o,
  output logic                  pll_bypass_o,
  output logic                  ready_o,
  output logic                  fault_o,
  output logic [LOSS_CNT_W-1:0] loss_count_o
);

  localparam int unsigned MaxA     = (LOCK_STABLE_CYCLES > PLL_RESET_CYCLES) ?
                                     LOCK_STABLE_CYCLES : PLL_RESET_CYCLES;
  localparam int unsigned MaxCount = (LOCK_TIMEOUT_CYCLES > MaxA) ? LOCK_TIMEOUT_CYCLES : MaxA;
  localparam int unsigned CntW     = cnt_width(MaxCount);
  localparam int unsigned RetryW   = cnt_width(MAX_RETRIES);

  localparam logic [CntW-1:0]   ResetLast   = CntW'(PLL_RESET_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLast   = RetryW'(MAX_RETRIES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;

  assign lk = sync_q[SYNC_STAGES-1];

  // Multi-flop synchroniser for the asynchronous PLL lock output.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lock_i};
    end
  end

  // State, counter and loss-count registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StOff;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic; a dropped enable overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (!enable_i) begin
      state_d = StOff;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        StOff: begin
          state_d = StReset;
          cnt_d   = '0;
          retry_d = '0;
        end
        StReset: begin
          if (cnt_q == ResetLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (lk) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            cnt_d = '0;
            if (retry_q == RetryLast) begin
              state_d = StFault;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = StReset;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStable: begin
          // A glitch restarts the timeout window but does not cost a retry.
          if (!lk) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StLocked;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StLocked: begin
          if (!lk) begin
            if (loss_q != '1) begin
              loss_d = loss_q + 1'b1;
            end
            state_d = StReset;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        StFault: begin
          if (clear_fault_i) begin
            state_d = StOff;
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  assign pll_resetb_o = state_q inside {StWaitLock, StStable, StLocked};
  assign pll_bypass_o = state_q inside {StOff, StFault};
  assign ready_o      = (state_q == StLocked);
  assign fault_o      = (state_q == StFault);
  assign loss_count_o = loss_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervisor for NUM_CH PLLs: per-channel sequencers plus a registered all-ready flag.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned NUM_CH              = 1,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned LOSS_CNT_W          = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [NUM_CH-1:0]            enable_i,
  input  logic [NUM_CH-1:0]            clear_fault_i,
  input  logic [NUM_CH-1:0]            lock_i,
  output logic [NUM_CH-1:0]            pll_resetb_o,
  output logic [NUM_CH-1:0]            pll_bypass_o,
  output logic [NUM_CH-1:0]            ready_o,
  output logic                         all_ready_o,
  output logic [NUM_CH-1:0]            fault_o,
  output logic [NUM_CH*LOSS_CNT_W-1:0] loss_count_o
);

  logic all_ready_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pll_sup_channel #(
      .SYNC_STAGES        (SYNC_STAGES),
      .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
      .PLL_RESET_CYCLES   (PLL_RESET_CYCLES),
      .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
      .MAX_RETRIES        (MAX_RETRIES),
      .LOSS_CNT_W         (LOSS_CNT_W)
    ) u_channel (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .enable_i     (enable_i[g]),
      .clear_fault_i(clear_fault_i[g]),
      .lock_i       (lock_i[g]),
      .pll_resetb_o (pll_resetb_o[g]),
      .pll_bypass_o (pll_bypass_o[g]),
      .ready_o      (ready_o[g]),
      .fault_o      (fault_o[g]),
      .loss_count_o (loss_count_o[g*LOSS_CNT_W +: LOSS_CNT_W])
    );
  end

  // Registered AND so the reset tree sees a clean, glitch-free release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      all_ready_q <= 1'b0;
    end else begin
      all_ready_q <= &ready_o;
    end
  end

  assign all_ready_o = all_ready_q;

endmodule
